tm_lif_array: RTL

Parametrised time-multiplexed leaky integrate-and-fire neuron array. It is the successor to the fixed 8-neuron/8-bit TM LIF block.
- One shared update datapath services N_NEURONS neurons round-robin, one neuron per enabled cycle.
- Adds per-neuron programmable thresholds, saturating integration, a configurable leak shift, a refractory period, and a spike event strobe.
- Sits between the input current source, which supplies the current for the neuron named by sel_idx, and the spike consumer or readout logic.

---
 rtl/tm_lif_array.sv | 123 ++++++++++++
 1 files changed

// File: rtl/tm_lif_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array: one shared update
// datapath visits each neuron round-robin, one neuron per enabled cycle.
module tm_lif_array #(
    parameter int N_NEURONS      = 8,
    parameter int W              = 8,
    parameter int LEAK_SHIFT     = 1,
    parameter int REF_W          = 3,
    parameter int THRESH_DEFAULT = 127,
    parameter int IDX_W          = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [W-1:0]         current,
    output logic [IDX_W-1:0]     sel_idx,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_addr,
    input  logic [W-1:0]         cfg_thresh,
    input  logic [REF_W-1:0]     refrac_len,
    output logic [N_NEURONS-1:0] spike,
    output logic                 spike_valid,
    output logic [IDX_W-1:0]     spike_idx,
    output logic [W-1:0]         state_out,
    output logic                 frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W:0]   N_EXT       = (IDX_W + 1)'(N_NEURONS);
    localparam logic [W-1:0]     THRESH_INIT = W'(THRESH_DEFAULT);

    logic [W-1:0]         mem_q    [N_NEURONS];
    logic [W-1:0]         thresh_q [N_NEURONS];
    logic [REF_W-1:0]     refrac_q [N_NEURONS];
    logic [IDX_W-1:0]     selIdx_q;
    logic [N_NEURONS-1:0] spike_q;
    logic                 spikeValid_q;
    logic [IDX_W-1:0]     spikeIdx_q;
    logic [W-1:0]         stateOut_q;
    logic                 frameDone_q;

    logic [W-1:0]         leaked;
    logic [W:0]           sum;
    logic [W-1:0]         integ;
    logic                 inRefrac;
    logic                 fire_d;
    logic [W-1:0]         mem_d;
    logic [REF_W-1:0]     refrac_d;
    logic                 lastNeuron;
    logic [IDX_W-1:0]     selIdx_d;
    logic                 cfgInRange;

    // Datapath for the neuron under service; the threshold is read from the
    // register array, so a same-edge config write is only seen next visit.
    always_comb begin
        leaked     = mem_q[selIdx_q] >> LEAK_SHIFT;
        sum        = {1'b0, leaked} + {1'b0, current};
        integ      = sum[W] ? '1 : sum[W-1:0];
        inRefrac   = (refrac_q[selIdx_q] != '0);
        fire_d     = !inRefrac && (integ >= thresh_q[selIdx_q]);
        mem_d      = (inRefrac || fire_d) ? '0 : integ;
        refrac_d   = '0;
        if (inRefrac) begin
            refrac_d = refrac_q[selIdx_q] - 1'b1;
        end else if (fire_d) begin
            refrac_d = refrac_len;
        end
        lastNeuron = (selIdx_q == LAST_IDX);
        selIdx_d   = lastNeuron ? '0 : selIdx_q + 1'b1;
        cfgInRange = ({1'b0, cfg_addr} < N_EXT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i]    <= '0;
                refrac_q[i] <= '0;
            end
        end else if (en) begin
            mem_q[selIdx_q]    <= mem_d;
            refrac_q[selIdx_q] <= refrac_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                thresh_q[i] <= THRESH_INIT;
            end
        end else if (cfg_we && cfgInRange) begin
            thresh_q[cfg_addr] <= cfg_thresh;
        end
    end

    // Scheduler and registered result outputs; strobes drop whenever idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selIdx_q     <= '0;
            spike_q      <= '0;
            spikeValid_q <= 1'b0;
            spikeIdx_q   <= '0;
            stateOut_q   <= '0;
            frameDone_q  <= 1'b0;
        end else if (en) begin
            selIdx_q          <= selIdx_d;
            spike_q[selIdx_q] <= fire_d;
            spikeValid_q      <= fire_d;
            spikeIdx_q        <= selIdx_q;
            stateOut_q        <= mem_d;
            frameDone_q       <= lastNeuron;
        end else begin
            spikeValid_q <= 1'b0;
            frameDone_q  <= 1'b0;
        end
    end

    assign sel_idx     = selIdx_q;
    assign spike       = spike_q;
    assign spike_valid = spikeValid_q;
    assign spike_idx   = spikeIdx_q;
    assign state_out   = stateOut_q;
    assign frame_done  = frameDone_q;

endmodule
